// File: rtl/lock_key_loader.sv
// ---------------------------------------------------------------------------
// lock_key_loader
//
// Run-time unlock controller for an XOR-locked ripple-carry adder. On a start
// pulse it reads the key from the key store one word at a time into a shadow
// register. It then drives the key onto the adder's key bus and runs four
// fixed self-test vectors through the adder. Each adder result is compared
// against an internally computed golden sum. The key stays on the bus only
// if every vector matches.
//
// Ports
//   clk_i        system clock, rising-edge active
//   rst_i        synchronous active-high reset
//   start_i      start pulse, accepted only in IDLE, PASS or FAIL
//   mem_rd_o     key-store read request
//   mem_addr_o   key-store word address
//   mem_rdata_i  key-store read data
//   mem_valid_i  read data valid (same cycle as request or later)
//   keyinput_o   key bus to the locked adder
//   add1_o       adder operand A
//   add2_o       adder operand B
//   result_i     combinational adder result, DATA_W+1 bits
//   busy_o       load/self-test in progress
//   pass_o       key verified (level)
//   fail_o       self-test mismatch (level)
//
// KEY_W must equal WORD_W*NUM_WORDS, and NUM_WORDS must fit the 2-bit address.
// ---------------------------------------------------------------------------
module lock_key_loader #(
  parameter int KEY_W     = 64,
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 4,
  parameter int DATA_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              mem_rd_o,
  output logic [1:0]        mem_addr_o,
  input  logic [WORD_W-1:0] mem_rdata_i,
  input  logic              mem_valid_i,
  output logic [KEY_W-1:0]  keyinput_o,
  output logic [DATA_W-1:0] add1_o,
  output logic [DATA_W-1:0] add2_o,
  input  logic [DATA_W:0]   result_i,
  output logic              busy_o,
  output logic              pass_o,
  output logic              fail_o
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    APPLY,
    CHECK,
    PASS,
    FAIL
  } state_t;

  localparam logic [1:0] LAST_WORD = 2'(NUM_WORDS - 1);
  localparam logic [1:0] LAST_VEC  = 2'd3;

  state_t              state;
  state_t              state_next;
  logic [KEY_W-1:0]    shadow;
  logic [1:0]          word_cnt;
  logic [1:0]          vec_cnt;
  logic [DATA_W-1:0]   vec_a;
  logic [DATA_W-1:0]   vec_b;
  logic [DATA_W:0]     golden;
  logic                sum_ok;
  logic                start_ok;
  logic                capture;
  logic                testing;

  // Self-test vector table, chosen to exercise an all-zero add, a full
  // carry ripple into the carry-out, alternating bit patterns and a
  // mixed-value sum.
  always_comb begin
    vec_a = '0;
    vec_b = '0;
    case (vec_cnt)
      2'd1: begin
        vec_a = DATA_W'(32'hFFFF_FFFF);
        vec_b = DATA_W'(32'h0000_0001);
      end
      2'd2: begin
        vec_a = DATA_W'(32'hAAAA_AAAA);
        vec_b = DATA_W'(32'h5555_5555);
      end
      2'd3: begin
        vec_a = DATA_W'(32'h1234_5678);
        vec_b = DATA_W'(32'h9ABC_DEF0);
      end
      default: begin
        vec_a = '0;
        vec_b = '0;
      end
    endcase
  end

  // Golden sum is one bit wider than the operands so the carry-out is
  // checked as well.
  assign golden   = {1'b0, add1_o} + {1'b0, add2_o};
  assign sum_ok   = (result_i == golden);
  assign start_ok = start_i && (state == IDLE || state == PASS || state == FAIL);
  assign capture  = (state == READ) && mem_valid_i;
  assign testing  = (state == APPLY) || (state == CHECK);

  // All outputs decode the registered state. mem_rd_o therefore falls in the
  // cycle after the last word is captured, and falls straight after a reset.
  assign mem_rd_o   = (state == READ);
  assign mem_addr_o = (state == READ) ? word_cnt : 2'd0;
  assign busy_o     = (state == READ) || testing;
  assign pass_o     = (state == PASS);
  assign fail_o     = (state == FAIL);
  assign keyinput_o = (testing || state == PASS) ? shadow : '0;
  assign add1_o     = testing ? vec_a : '0;
  assign add2_o     = testing ? vec_b : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, PASS, FAIL: begin
        if (start_ok) begin
          state_next = READ;
        end
      end
      READ: begin
        if (mem_valid_i && word_cnt == LAST_WORD) begin
          state_next = APPLY;
        end
      end
      APPLY: begin
        state_next = CHECK;
      end
      CHECK: begin
        if (!sum_ok) begin
          state_next = FAIL;
        end else if (vec_cnt == LAST_VEC) begin
          state_next = PASS;
        end else begin
          state_next = APPLY;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Shadow key and counters. The shadow is wiped on every restart and on a
  // self-test mismatch, so a rejected key never lingers in the design.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow   <= '0;
      word_cnt <= 2'd0;
      vec_cnt  <= 2'd0;
    end else if (start_ok) begin
      shadow   <= '0;
      word_cnt <= 2'd0;
      vec_cnt  <= 2'd0;
    end else if (capture) begin
      shadow[WORD_W*int'(word_cnt) +: WORD_W] <= mem_rdata_i;
      word_cnt <= (word_cnt == LAST_WORD) ? 2'd0 : word_cnt + 2'd1;
      vec_cnt  <= 2'd0;
    end else if (state == CHECK) begin
      if (!sum_ok) begin
        shadow <= '0;
      end else if (vec_cnt != LAST_VEC) begin
        vec_cnt <= vec_cnt + 2'd1;
      end
    end
  end

endmodule

// File: doc/lock_key_loader.md
Name: lock_key_loader

Overview:
- Run-time unlock controller for the XOR-locked 32-bit ripple-carry adder.
- Reads the 64-bit key from the key store one 16-bit word at a time and drives it onto the locked adder's keyinput bus.
- Applies a fixed set of self-test vectors to the adder and checks each 33-bit result against an internal golden sum.
- Reports pass or fail, and releases the key only on pass.

Parameters:
- KEY_W, 64, total key width; must equal WORD_W*NUM_WORDS.
- WORD_W, 16, key-store read width.
- NUM_WORDS, 4, key-store words read per load.
- DATA_W, 32, adder operand width; the result is DATA_W+1 bits.

Ports:
- clk_i  in  1  system clock; all state changes on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle pulse that starts load plus self-test; honoured only in IDLE, PASS or FAIL.
- mem_rd_o  out  1  key-store read request.
- mem_addr_o  out  2  key-store word address.
- mem_rdata_i  in  WORD_W  key-store read data.
- mem_valid_i  in  1  read data valid; may arrive in the request cycle or any later cycle.
- keyinput_o  out  KEY_W  key bus to the locked adder.
- add1_o  out  DATA_W  operand A to the locked adder.
- add2_o  out  DATA_W  operand B to the locked adder.
- result_i  in  DATA_W+1  combinational result from the locked adder.
- busy_o  out  1  high from the cycle after start_i until PASS or FAIL is entered.
- pass_o  out  1  level; key verified.
- fail_o  out  1  level; self-test mismatch.

Behaviour:
- Reset values:
  - State IDLE.
  - keyinput_o=0, add1_o=0, add2_o=0, mem_rd_o=0, mem_addr_o=0.
  - busy_o=0, pass_o=0, fail_o=0.
  - Internal key shadow register and word/vector counters cleared.
- States: IDLE, READ, APPLY, CHECK, PASS, FAIL.
- IDLE, PASS or FAIL with start_i=1 -> READ:
  - Clear the shadow key register, both counters, pass_o and fail_o.
  - Drive keyinput_o to 0.
- READ:
  - mem_rd_o=1 and mem_addr_o=word counter k, held stable until mem_valid_i.
  - When mem_valid_i=1, capture mem_rdata_i into shadow[WORD_W*k +: WORD_W].
  - If k=NUM_WORDS-1, go to APPLY with vector 0. Otherwise increment k and stay in READ.
  - mem_rd_o is registered: it drops the cycle after the last capture.
  - mem_valid_i outside READ is ignored.
  - Minimum READ duration is NUM_WORDS cycles.
- APPLY vector v:
  - keyinput_o=shadow key; add1_o/add2_o = vector v.
  - Lasts one cycle (settle), then go to CHECK.
- CHECK vector v:
  - Compare result_i with golden = zero-extended add1_o + add2_o, computed as a DATA_W+1-bit sum; carry-out is bit DATA_W.
  - Mismatch -> FAIL.
  - Match with v=3 -> PASS.
  - Match otherwise -> APPLY with v+1.
- Vectors (A, B):
  - v0: (0, 0)
  - v1: (FFFFFFFF, 00000001)
  - v2: (AAAAAAAA, 55555555)
  - v3: (12345678, 9ABCDEF0)
- PASS:
  - pass_o=1; keyinput_o holds the shadow key.
  - add1_o/add2_o return to 0.
  - Holds until start_i or rst_i.
- FAIL:
  - fail_o=1; keyinput_o forced to 0 (the key is never left on the bus after a mismatch).
  - Shadow register cleared.
  - Holds until start_i or rst_i.
- Outside READ/APPLY/CHECK/PASS, keyinput_o=0.
- pass_o and fail_o are never high together.
- Timing with zero-wait memory: start_i at cycle 0; READ cycles 1-4; APPLY/CHECK cycles 5-12; pass_o or fail_o high from cycle 13.
- start_i while busy_o=1 is ignored; start_i in PASS/FAIL restarts.
- rst_i mid-read or mid-test: next cycle all outputs return to reset values and mem_rd_o drops immediately.

Test Plan:
- Correct key: key store words {addr0..3} = CDEF, 89AB, 4567, 0123 (key 0123456789ABCDEF). Bench adder model returns the true sum for this key, zero-wait memory -> mem_addr_o sequence 0,1,2,3; keyinput_o=0123456789ABCDEF from cycle 5; CHECK at v1 sees 100000000; pass_o=1 at cycle 13; busy_o low at cycle 13.
- Wrong key: bench adder model returns sum with bit 7 flipped on v2 -> fail_o=1 immediately after CHECK v2 (cycle 11); keyinput_o=0; v3 never applied.
- Memory wait states: mem_valid_i delayed 3 cycles on word 2 -> mem_addr_o holds 2 for 4 cycles; shadow word 2 equals data sampled on the valid cycle; pass asserted 3 cycles later than the zero-wait case.
- Reset mid-operation: rst_i during READ word 1 -> next cycle mem_rd_o=0, busy_o=0, keyinput_o=0. A fresh start_i then completes normally.
- Start while busy: start_i pulsed in APPLY v1 -> ignored, sequence unchanged. start_i in PASS -> pass_o clears next cycle and keyinput_o=0 during the re-read.
- Carry-out check: bench adder model drops result_i[32] on v1 (returns 000000000) -> fail_o=1.
